// File: rtl/alu_rs_issue_pkg.sv
// Shared types for the integer ALU reservation station.
//   alu_rs_entry_t : one RS slot (operands either present or waiting on a ROB tag)
//   data_bus_t     : result broadcast {valid, dest_rob, value}
//   rs_to_alu_t    : registered issue record presented to the ALU
//   snoop_t        : result of matching one tag against all result buses
// ALU opcode encoding: 000 add, 001 sll, 010 sra, 011 sub, 100 xor, 101 srl, 110 or, 111 and.
package alu_rs_issue_pkg;

  localparam int unsigned ALU_RS_DEPTH = 8;
  localparam int unsigned ROB_W        = 4;
  localparam int unsigned NUM_CDB      = 5;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] dest_rob;
    logic [31:0]      value;
  } data_bus_t;

  typedef struct packed {
    logic             ld_alu;
    logic [2:0]       alu_op;
    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [ROB_W-1:0] rob_idx;
  } rs_to_alu_t;

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [ROB_W-1:0] rob;
    logic             s1_rdy;
    logic [ROB_W-1:0] s1_tag;
    logic [31:0]      s1_val;
    logic             s2_rdy;
    logic [ROB_W-1:0] s2_tag;
    logic [31:0]      s2_val;
  } alu_rs_entry_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } snoop_t;

endpackage

// File: rtl/alu_rs_issue_select.sv
// Combinational oldest-ready picker.
//   eligible_i    : entries that are valid with both operands ready
//   age_i         : age matrix, row i bit j set when entry i is older than entry j
//   grant_o       : one-hot grant of the oldest eligible entry
//   grant_valid_o : some entry is eligible
module alu_rs_issue_select #(
  parameter int unsigned Depth = 8
) (
  input  logic [Depth-1:0]            eligible_i,
  input  logic [Depth-1:0][Depth-1:0] age_i,
  output logic [Depth-1:0]            grant_o,
  output logic                        grant_valid_o
);

  // older_than[i][j]: entry j is older than entry i (column i of the age matrix)
  logic [Depth-1:0][Depth-1:0] older_than;

  always_comb begin
    older_than = '0;
    grant_o    = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      for (int unsigned j = 0; j < Depth; j++) begin
        older_than[i][j] = (i != j) && age_i[j][i];
      end
      // Granted when no other eligible entry is older
      grant_o[i] = eligible_i[i] & ~|(eligible_i & older_than[i]);
    end
    grant_valid_o = |eligible_i;
  end

endmodule

// File: rtl/alu_rs_issue.sv
// Reservation station for the integer ALU path. Holds dispatched ALU ops, snoops the result
// buses for missing operands and issues the oldest operand-ready op each cycle as a registered
// record the ALU consumes in the cycle it is presented.
//   clk_i / rst_ni     : clock, asynchronous active-low reset
//   flush_i            : squash all entries and the pending issue record
//   disp_*             : dispatch request and operands; disp_ready_o = not full
//   cdb_i              : result buses snooped for waiting operands
//   iss_o              : registered issue record (ld_alu high for one cycle per op)
//   occupancy_o        : number of valid entries
// Optional build macro ALU_RS_PERF_EN adds saturating counters perf_full_cyc_o and
// perf_issued_o, cleared by reset and flush.
module alu_rs_issue
  import alu_rs_issue_pkg::*;
#(
  parameter int unsigned Depth  = ALU_RS_DEPTH,
  parameter int unsigned NumCdb = NUM_CDB
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        disp_valid_i,
  output logic                        disp_ready_o,
  input  logic [2:0]                  disp_op_i,
  input  logic [ROB_W-1:0]            disp_rob_i,
  input  logic                        disp_s1_rdy_i,
  input  logic [ROB_W-1:0]            disp_s1_tag_i,
  input  logic [31:0]                 disp_s1_val_i,
  input  logic                        disp_s2_rdy_i,
  input  logic [ROB_W-1:0]            disp_s2_tag_i,
  input  logic [31:0]                 disp_s2_val_i,
  input  data_bus_t [NumCdb-1:0]      cdb_i,
  output rs_to_alu_t                  iss_o,
  output logic [$clog2(Depth):0]      occupancy_o
`ifdef ALU_RS_PERF_EN
  ,
  output logic [31:0]                 perf_full_cyc_o,
  output logic [31:0]                 perf_issued_o
`endif
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth) + 1;

  alu_rs_entry_t               entries_q [Depth];
  alu_rs_entry_t               entries_d [Depth];
  logic [Depth-1:0][Depth-1:0] age_q, age_d;
  rs_to_alu_t                  iss_q, iss_d;

  logic [Depth-1:0] valid, eligible, grant;
  logic             grant_valid, disp_fire;
  logic [IdxW-1:0]  free_idx;
  snoop_t           s1_snp [Depth];
  snoop_t           s2_snp [Depth];
  snoop_t           disp_s1_snp, disp_s2_snp;

  // Iterating downwards lets the lowest-numbered matching bus win
  function automatic snoop_t snoop(input data_bus_t [NumCdb-1:0] bus,
                                   input logic [ROB_W-1:0] tag);
    snoop_t r;
    r = '0;
    for (int k = int'(NumCdb) - 1; k >= 0; k--) begin
      if (bus[k].valid && bus[k].dest_rob == tag) begin
        r.hit = 1'b1;
        r.val = bus[k].value;
      end
    end
    return r;
  endfunction

  always_comb begin
    occupancy_o = '0;
    free_idx    = '0;
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      valid[i]    = entries_q[i].valid;
      eligible[i] = entries_q[i].valid & entries_q[i].s1_rdy & entries_q[i].s2_rdy;
      s1_snp[i]   = snoop(cdb_i, entries_q[i].s1_tag);
      s2_snp[i]   = snoop(cdb_i, entries_q[i].s2_tag);
      occupancy_o = occupancy_o + OccW'(entries_q[i].valid);
      if (!entries_q[i].valid) free_idx = IdxW'(i);
    end
    disp_s1_snp = snoop(cdb_i, disp_s1_tag_i);
    disp_s2_snp = snoop(cdb_i, disp_s2_tag_i);
  end

  // Full is judged on current occupancy only; a same-cycle issue does not reopen the slot
  assign disp_ready_o = (occupancy_o != OccW'(Depth));
  assign disp_fire    = disp_valid_i & disp_ready_o;

  alu_rs_issue_select #(
    .Depth (Depth)
  ) u_select (
    .eligible_i    (eligible),
    .age_i         (age_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    entries_d = entries_q;
    age_d     = age_q;
    iss_d     = '0;

    // Wakeup
    for (int unsigned i = 0; i < Depth; i++) begin
      if (entries_q[i].valid) begin
        if (!entries_q[i].s1_rdy && s1_snp[i].hit) begin
          entries_d[i].s1_rdy = 1'b1;
          entries_d[i].s1_val = s1_snp[i].val;
        end
        if (!entries_q[i].s2_rdy && s2_snp[i].hit) begin
          entries_d[i].s2_rdy = 1'b1;
          entries_d[i].s2_val = s2_snp[i].val;
        end
      end
    end

    // Issue the granted entry
    if (grant_valid) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (grant[i]) begin
          entries_d[i].valid = 1'b0;
          iss_d.ld_alu       = 1'b1;
          iss_d.alu_op       = entries_q[i].op;
          iss_d.alu_src1     = entries_q[i].s1_val;
          iss_d.alu_src2     = entries_q[i].s2_val;
          iss_d.rob_idx      = entries_q[i].rob;
        end
      end
    end

    // Allocate; same-cycle bus results are captured directly
    if (disp_fire) begin
      entries_d[free_idx].valid  = 1'b1;
      entries_d[free_idx].op     = disp_op_i;
      entries_d[free_idx].rob    = disp_rob_i;
      entries_d[free_idx].s1_rdy = disp_s1_rdy_i | disp_s1_snp.hit;
      entries_d[free_idx].s1_tag = disp_s1_tag_i;
      entries_d[free_idx].s1_val = disp_s1_rdy_i ? disp_s1_val_i : disp_s1_snp.val;
      entries_d[free_idx].s2_rdy = disp_s2_rdy_i | disp_s2_snp.hit;
      entries_d[free_idx].s2_tag = disp_s2_tag_i;
      entries_d[free_idx].s2_val = disp_s2_rdy_i ? disp_s2_val_i : disp_s2_snp.val;
      // New entry is younger than every resident entry
      age_d[free_idx] = '0;
      for (int unsigned j = 0; j < Depth; j++) begin
        if (valid[j]) age_d[j][free_idx] = 1'b1;
      end
    end

    if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) entries_d[i].valid = 1'b0;
      iss_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) entries_q[i] <= '0;
      age_q <= '0;
      iss_q <= '0;
    end else begin
      entries_q <= entries_d;
      age_q     <= age_d;
      iss_q     <= iss_d;
    end
  end

  assign iss_o = iss_q;

`ifdef ALU_RS_PERF_EN
  logic [31:0] perf_full_q, perf_issued_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_full_q   <= '0;
      perf_issued_q <= '0;
    end else if (flush_i) begin
      perf_full_q   <= '0;
      perf_issued_q <= '0;
    end else begin
      if (!disp_ready_o && perf_full_q != '1) perf_full_q <= perf_full_q + 32'd1;
      if (iss_q.ld_alu && perf_issued_q != '1) perf_issued_q <= perf_issued_q + 32'd1;
    end
  end

  assign perf_full_cyc_o = perf_full_q;
  assign perf_issued_o   = perf_issued_q;
`endif

endmodule
